// File: rtl/bp_me_stream_pump_out_pkg.sv
// Shared BedRock memory-message types and beat-count helpers used by the stream pumps.
package bp_me_stream_pump_out_pkg;

    localparam int paddr_width_gp   = 40;
    localparam int payload_width_gp = 16;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        logic [paddr_width_gp-1:0]   addr;
        bp_bedrock_msg_size_e        size;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

    // Number of stream beats a message of this size occupies (at least one).
    function automatic int unsigned stream_num_beats(input bp_bedrock_msg_size_e size,
                                                     input int unsigned stream_offset_width);
        int unsigned n;
        n = (32'd1 << size) >> stream_offset_width;
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

    // Untruncated index of the final beat; callers keep only the counter-width bits.
    function automatic int unsigned stream_last_cnt(input int unsigned first_cnt,
                                                    input int unsigned num_beats);
        return first_cnt + num_beats - 32'd1;
    endfunction

endpackage

// File: rtl/bp_me_stream_out_buffer.sv
// Two-entry ready/valid buffer; accepts a push while full if the head is popped that cycle.
module bp_me_stream_out_buffer
    import bp_me_stream_pump_out_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_and_i
);

    logic [width_p-1:0] mem_r [2];
    logic               wptr_r, rptr_r;
    logic [1:0]         count_r;
    logic               enq, deq;

    assign v_o         = |count_r;
    assign deq         = v_o & ready_and_i;
    assign ready_and_o = ~count_r[1] | deq;
    assign enq         = v_i & ready_and_o;
    assign data_o      = mem_r[rptr_r];

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            count_r <= count_r + {1'b0, enq} - {1'b0, deq};
        end
    end

    // NOTE: storage has no reset; count_r keeps stale entries from ever being presented.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_me_stream_pump_out.sv
// Outbound BedRock stream pump: converts FSM beats into wrapped-address stream beats (1:1, N:1, 1:N).
module bp_me_stream_pump_out
    import bp_me_stream_pump_out_pkg::*;
#(
    parameter int          stream_data_width_p = 64,
    parameter int          block_width_p       = 512,
    parameter logic [15:0] mem_stream_mask_p   = '0,
    parameter logic [15:0] fsm_stream_mask_p   = mem_stream_mask_p,

    localparam int stream_words_lp        = block_width_p / stream_data_width_p,
    localparam int data_len_width_lp      = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1,
    localparam int stream_offset_width_lp = ((stream_data_width_p/8) > 1) ? $clog2(stream_data_width_p/8) : 1,
    localparam int block_offset_width_lp  = ((block_width_p/8) > 1) ? $clog2(block_width_p/8) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [mem_header_width_gp-1:0] fsm_base_header_i,
    input  logic [stream_data_width_p-1:0] fsm_data_i,
    input  logic                           fsm_v_i,
    output logic                           fsm_ready_and_o,
    output logic [data_len_width_lp-1:0]   fsm_cnt_o,
    output logic                           fsm_new_o,
    output logic                           fsm_done_o,
    output logic [mem_header_width_gp-1:0] mem_header_o,
    output logic [stream_data_width_p-1:0] mem_data_o,
    output logic                           mem_v_o,
    output logic                           mem_last_o,
    input  logic                           mem_ready_and_i
);

    localparam int buf_width_lp = mem_header_width_gp + stream_data_width_p + 1;

    bp_bedrock_mem_header_s         hdr, push_hdr;
    logic [data_len_width_lp-1:0]   cnt;
    logic                           is_fsm_stream, is_mem_stream, is_last, streaming_r;
    logic                           push_v, push_last, buf_ready, fsm_ready_raw, advance;
    logic [mem_header_width_gp-1:0] hdr_q;

    assign hdr = bp_bedrock_mem_header_s'(fsm_base_header_i);

    if (stream_words_lp > 1) begin : g_multi
        logic [data_len_width_lp-1:0] first_cnt, last_cnt, sel_mask, wrap_idx, cnt_r;
        int unsigned                  num_stream;

        always_comb begin
            num_stream = stream_num_beats(hdr.size, stream_offset_width_lp);
            first_cnt  = hdr.addr[stream_offset_width_lp +: data_len_width_lp];
            last_cnt   = data_len_width_lp'(stream_last_cnt(32'(first_cnt), num_stream));
            sel_mask   = data_len_width_lp'(num_stream - 32'd1);
        end

        assign is_fsm_stream = fsm_stream_mask_p[hdr.msg_type] & (first_cnt != last_cnt);
        assign is_mem_stream = mem_stream_mask_p[hdr.msg_type] & (first_cnt != last_cnt);
        assign cnt           = streaming_r ? cnt_r : first_cnt;
        assign is_last       = (cnt == last_cnt) | (~is_fsm_stream & ~is_mem_stream);
        // Low index bits follow the counter, bits above the message size stay from addr.
        assign wrap_idx      = (cnt & sel_mask) | (first_cnt & ~sel_mask);

        always_comb begin
            push_hdr = hdr;
            push_hdr.addr[stream_offset_width_lp +: data_len_width_lp] = wrap_idx;
        end

        // Done wins over advance so a finished message always restarts from its own first_cnt.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_r       <= '0;
                streaming_r <= 1'b0;
            end else if (fsm_done_o) begin
                cnt_r       <= '0;
                streaming_r <= 1'b0;
            end else if (advance) begin
                cnt_r       <= cnt + 1'b1;
                streaming_r <= 1'b1;
            end
        end
    end else begin : g_single
        assign is_fsm_stream = 1'b0;
        assign is_mem_stream = 1'b0;
        assign cnt           = '0;
        assign is_last       = 1'b1;
        assign push_hdr      = hdr;
        assign streaming_r   = 1'b0;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push_v        = fsm_v_i;
        push_last     = is_last;
        fsm_ready_raw = buf_ready;
        if (is_fsm_stream & ~is_mem_stream) begin
            push_v        = fsm_v_i & is_last;
            push_last     = 1'b1;
            fsm_ready_raw = is_last ? buf_ready : 1'b1;
        end else if (is_mem_stream & ~is_fsm_stream) begin
            fsm_ready_raw = buf_ready & is_last;
        end
    end

    assign fsm_ready_and_o = reset_n_i & fsm_ready_raw;
    assign fsm_done_o      = is_last & fsm_v_i & fsm_ready_and_o;
    assign fsm_new_o       = reset_n_i & is_fsm_stream & ~streaming_r;
    assign fsm_cnt_o       = reset_n_i ? cnt : '0;
    assign advance         = ~is_last & ((is_fsm_stream & ~is_mem_stream)
                                         ? (fsm_v_i & fsm_ready_and_o)
                                         : (push_v & buf_ready));

    bp_me_stream_out_buffer #(.width_p(buf_width_lp)) out_buffer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .data_i      ({push_hdr, fsm_data_i, push_last}),
        .v_i         (push_v),
        .ready_and_o (buf_ready),
        .data_o      ({mem_header_o, mem_data_o, mem_last_o}),
        .v_o         (mem_v_o),
        .ready_and_i (mem_ready_and_i)
    );

    // Simulation guards: oversize messages and headers that move mid-message.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hdr_q <= '0;
        end else if (fsm_v_i) begin
            assert (int'(hdr.size) <= block_offset_width_lp);
            if (streaming_r) assert (fsm_base_header_i == hdr_q);
            hdr_q <= fsm_base_header_i;
        end
    end

endmodule

// File: tb/tb_bp_me_stream_pump_out.sv
// Directed bench for bp_me_stream_pump_out: 1:1, single-beat, 1:N, N:1, back-pressure and reset.
module tb_bp_me_stream_pump_out;
    import bp_me_stream_pump_out_pkg::*;

    localparam int hw = mem_header_width_gp;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [hw-1:0] fsm_base_header_i = '0;
    logic [63:0]   fsm_data_i = '0;
    logic          fsm_v_i = 1'b0;
    logic          fsm_ready_and_o;
    logic [2:0]    fsm_cnt_o;
    logic          fsm_new_o, fsm_done_o;
    logic [hw-1:0] mem_header_o;
    logic [63:0]   mem_data_o;
    logic          mem_v_o, mem_last_o;
    logic          mem_ready_and_i = 1'b1;

    int total = 0;
    int passed = 0;

    logic [39:0] t3_addr [4] = '{40'h2008, 40'h2010, 40'h2018, 40'h2000};
    logic [39:0] t7_addr [4] = '{40'h3018, 40'h3000, 40'h3008, 40'h3010};

    always #5 clk_i = ~clk_i;

    bp_me_stream_pump_out #(
        .stream_data_width_p (64),
        .block_width_p       (512),
        .mem_stream_mask_p   (16'h0003),
        .fsm_stream_mask_p   (16'h000A)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .fsm_base_header_i (fsm_base_header_i),
        .fsm_data_i        (fsm_data_i),
        .fsm_v_i           (fsm_v_i),
        .fsm_ready_and_o   (fsm_ready_and_o),
        .fsm_cnt_o         (fsm_cnt_o),
        .fsm_new_o         (fsm_new_o),
        .fsm_done_o        (fsm_done_o),
        .mem_header_o      (mem_header_o),
        .mem_data_o        (mem_data_o),
        .mem_v_o           (mem_v_o),
        .mem_last_o        (mem_last_o),
        .mem_ready_and_i   (mem_ready_and_i)
    );

    function automatic logic [hw-1:0] mk_hdr(input bp_bedrock_mem_type_e t,
                                             input bp_bedrock_msg_size_e s,
                                             input logic [39:0] a);
        bp_bedrock_mem_header_s h;
        h.msg_type = t;
        h.size     = s;
        h.addr     = a;
        h.payload  = 16'h5A3C;
        return h;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [hw-1:0] h, input logic [63:0] d, input logic rdy);
        @(negedge clk_i);
        fsm_v_i           = v;
        fsm_base_header_i = h;
        fsm_data_i        = d;
        mem_ready_and_i   = rdy;
        #1;
    endtask

    task automatic check_fsm(input string tag, input logic rdy, input logic [2:0] c,
                             input logic nw, input logic dn);
        check({tag, "_ready"}, 64'(fsm_ready_and_o), 64'(rdy));
        check({tag, "_cnt"},   64'(fsm_cnt_o),       64'(c));
        check({tag, "_new"},   64'(fsm_new_o),       64'(nw));
        check({tag, "_done"},  64'(fsm_done_o),      64'(dn));
    endtask

    task automatic check_out(input string tag, input logic [hw-1:0] h, input logic [63:0] d,
                             input logic last);
        check({tag, "_mem_v"},    64'(mem_v_o),      64'd1);
        check({tag, "_mem_hdr"},  64'(mem_header_o), 64'(h));
        check({tag, "_mem_data"}, mem_data_o,        d);
        check({tag, "_mem_last"}, 64'(mem_last_o),   64'(last));
    endtask

    initial begin
        logic [hw-1:0] h;
        int            k, j;
        logic          rdy;

        // Reset held with a live FSM beat: everything must read zero.
        h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h8010);
        drive(1'b1, h, 64'h0, 1'b1);
        check_fsm("rst", 1'b0, 3'd0, 1'b0, 1'b0);
        check("rst_mem_v", 64'(mem_v_o), 64'd0);
        drive(1'b0, h, 64'h0, 1'b1);
        reset_n_i = 1'b1;

        // 1:1 write, 64B at 0x8010: index order 2..7,0,1.
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, h, 64'hD1_0000 + 64'(i), 1'b1);
            if (i < 8) check_fsm("t1", 1'b1, 3'((2 + i) % 8), i == 0, i == 7);
            if (i > 0)
                check_out("t1", mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64,
                                       40'h8000 + 40'(((i + 1) % 8) * 8)),
                          64'hD1_0000 + 64'(i - 1), i == 8);
        end
        drive(1'b0, h, 64'h0, 1'b1);
        check("t1_idle_v", 64'(mem_v_o), 64'd0);

        // Uncached read, single 8B beat at 0x1004.
        h = mk_hdr(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h1004);
        drive(1'b1, h, 64'hD2D2_0000_1234_5678, 1'b1);
        check_fsm("t2", 1'b1, 3'd0, 1'b0, 1'b1);
        drive(1'b0, h, 64'h0, 1'b1);
        check_out("t2", h, 64'hD2D2_0000_1234_5678, 1'b1);
        check("t2_cnt_after", 64'(fsm_cnt_o), 64'd0);
        drive(1'b0, h, 64'h0, 1'b1);
        check("t2_idle_v", 64'(mem_v_o), 64'd0);

        // 1:N read, 32B at 0x2008: one held FSM beat fans out to four.
        h = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_32, 40'h2008);
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, h, 64'hD3D3_D3D3_0000_0003, 1'b1);
            if (i < 4) check_fsm("t3", i == 3, 3'(i + 1), 1'b0, i == 3);
            if (i > 0)
                check_out("t3", mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_32, t3_addr[i - 1]),
                          64'hD3D3_D3D3_0000_0003, i == 4);
        end
        drive(1'b0, h, 64'h0, 1'b1);
        check("t3_idle_v", 64'(mem_v_o), 64'd0);

        // N:1 uncached write, 64B at 0x4000: eight FSM beats collapse to the last one.
        h = mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_64, 40'h4000);
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, h, 64'hD4_0000 + 64'(i), 1'b1);
            if (i < 8) check_fsm("t4", 1'b1, 3'(i), i == 0, i == 7);
            if (i >= 1 && i < 8) check("t4_no_out", 64'(mem_v_o), 64'd0);
            if (i == 8)
                check_out("t4", mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_64, 40'h4038),
                          64'hD4_0007, 1'b1);
        end
        drive(1'b0, h, 64'h0, 1'b1);
        check("t4_idle_v", 64'(mem_v_o), 64'd0);

        // Back-pressure: consumer stalls cycles 2-5; buffer fills and drains in order.
        h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h8000);
        k = 0;
        j = 0;
        for (int c = 0; c < 16; c++) begin
            rdy = !(c >= 2 && c <= 5);
            drive(k < 8, h, 64'hD5_0000 + 64'(k), rdy);
            if (k < 8) check("t5_fsm_ready", 64'(fsm_ready_and_o), (c >= 3 && c <= 5) ? 64'd0 : 64'd1);
            check("t5_mem_v", 64'(mem_v_o), (c >= 1 && c <= 12) ? 64'd1 : 64'd0);
            if (c >= 1 && c <= 12) begin
                check_out("t5", mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64,
                                       40'h8000 + 40'(j * 8)),
                          64'hD5_0000 + 64'(j), j == 7);
                if (rdy) j++;
            end
            if (fsm_v_i && fsm_ready_and_o) k++;
        end
        check("t5_pushed", 64'(k), 64'd8);
        check("t5_popped", 64'(j), 64'd8);

        // Reset after three beats of a 64B write, then a fresh 32B write at 0x3018.
        h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h8010);
        for (int i = 0; i < 3; i++) drive(1'b1, h, 64'hD6_0000 + 64'(i), 1'b1);
        drive(1'b1, h, 64'hD6_0003, 1'b1);
        check("t6_pre_v", 64'(mem_v_o), 64'd1);
        reset_n_i = 1'b0;
        #1;
        check("t6_rst_mem_v", 64'(mem_v_o), 64'd0);
        check_fsm("t6_rst", 1'b0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, h, 64'h0, 1'b1);
        reset_n_i = 1'b1;
        h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_32, 40'h3018);
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, h, 64'hD7_0000 + 64'(i), 1'b1);
            if (i < 4) check_fsm("t7", 1'b1, 3'(3 + i), i == 0, i == 3);
            if (i > 0)
                check_out("t7", mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_32, t7_addr[i - 1]),
                          64'hD7_0000 + 64'(i - 1), i == 4);
        end
        drive(1'b0, h, 64'h0, 1'b1);
        check("t7_idle_v", 64'(mem_v_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bp_me_stream_pump_out.md
Name: bp_me_stream_pump_out

Overview:
Outbound counterpart of the BedRock Stream input pump. It accepts header/data beats from a producer FSM (cache, CCE, or memory responder) and emits a legal BedRock Stream message with wrapped per-beat addresses and a correct last flag. It performs the 1:1, 1:N and N:1 beat conversions selected by the two stream masks. Beats leave through a two-entry output buffer.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p and cce_block_width_p.
stream_data_width_p, dword_width_gp, width of one stream beat in bits.
block_width_p, cce_block_width_p, maximum message payload in bits.
mem_stream_mask_p, 0, one bit per bp_bedrock_mem_type_e; set bits mark msg types that are multi-beat on the outbound stream side.
fsm_stream_mask_p, mem_stream_mask_p, one bit per msg type; set bits mark msg types that are multi-beat on the FSM side.
Localparams: stream_words_lp = block_width_p/stream_data_width_p; data_len_width_lp = SAFE_CLOG2(stream_words_lp); stream_offset_width_lp = SAFE_CLOG2(stream_data_width_p/8); block_offset_width_lp = SAFE_CLOG2(block_width_p/8).

Ports:
clk_i  in  1  single clock; all state on rising edge.
reset_n_i  in  1  asynchronous reset, active-low.
fsm_base_header_i  in  xce_mem_msg_header_width_lp  header; addr is the critical-word address; held stable for the whole message.
fsm_data_i  in  stream_data_width_p  beat data.
fsm_v_i  in  1  FSM beat valid.
fsm_ready_and_o  out  1  beat accepted when fsm_v_i & fsm_ready_and_o.
fsm_cnt_o  out  data_len_width_lp  wrapped beat index of the current FSM beat.
fsm_new_o  out  1  current FSM beat is the first beat of a multi-beat FSM-side message.
fsm_done_o  out  1  current FSM handshake completes the message.
mem_header_o  out  xce_mem_msg_header_width_lp  outbound header; addr is the per-beat wrapped address.
mem_data_o  out  stream_data_width_p  outbound beat data.
mem_v_o  out  1  outbound valid.
mem_last_o  out  1  final beat of the outbound message.
mem_ready_and_i  in  1  consumer ready (ready-and-valid protocol).

Behaviour:
- Reset is asynchronous. While reset_n_i = 0: beat counter = 0, streaming_r = 0, buffer empty, mem_v_o = 0, fsm_ready_and_o = 0, and fsm_new_o, fsm_done_o, fsm_cnt_o are all 0.
- Reset asserted mid-message drops the partial message. The first beat after release is treated as a new message.
- Beat count: num_stream = max((1<<size)/(stream_data_width_p/8), 1).
- Counter bounds: first_cnt = addr[stream_offset_width_lp +: data_len_width_lp]; last_cnt = first_cnt + num_stream - 1, truncated to data_len_width_lp bits.
- is_fsm_stream = fsm_stream_mask_p[msg_type] & (first_cnt != last_cnt). is_mem_stream is defined the same way from mem_stream_mask_p.
- cnt = streaming_r ? counter : first_cnt. is_last = (cnt == last_cnt) | (~is_fsm_stream & ~is_mem_stream).
- Address wrap: sel_mask = num_stream - 1. Each bit of the beat index is taken from cnt where sel_mask is 1 and from the header addr where it is 0 (bitwise mux).
- Outbound addr = {upper addr bits, wrapped index, addr low stream-offset bits}. All other header fields pass through unchanged.
- Example, 256-bit message starting at word 2: index sequence 2, 3, 0, 1.
- 1:1 mode (both stream flags set, or neither set):
  - Each accepted FSM beat pushes exactly one buffer entry, with mem_last = is_last.
  - fsm_ready_and_o = buffer ready.
- N:1 mode (is_fsm_stream & ~is_mem_stream):
  - Non-last FSM beats are accepted unconditionally (fsm_ready_and_o = 1) and are not pushed.
  - The last FSM beat waits for buffer ready and pushes one entry with mem_last = 1.
- 1:N mode (is_mem_stream & ~is_fsm_stream):
  - The FSM beat is held, not acked. Each buffer push replicates fsm_data_i with an advancing address.
  - fsm_ready_and_o asserts only on the last push.
- Counter update:
  - Advances on each non-last push (1:1, 1:N) or non-last accept (N:1).
  - Set to first_cnt + 1 when the message starts; cleared to 0 on the message-done event.
  - streaming_r: set on advance, cleared on done; clear wins when both occur.
- fsm_new_o = is_fsm_stream & ~streaming_r.
- fsm_done_o = is_last & fsm_v_i & fsm_ready_and_o.
- fsm_cnt_o = cnt.
- Latency: an accepted push appears on mem_* on the next cycle.
- Throughput: 1 beat/cycle while mem_ready_and_i = 1.
- Buffer full: pushes stall and no beat is lost.
- Output stability: mem_* hold stable while mem_v_o & ~mem_ready_and_i.
- A simultaneous push and pop is legal when the buffer is full.
- Single-word config (stream_words_lp = 1): no counter; is_last = 1 and the addr is passed through.
- Illegal and undefined (assert in simulation): header changes mid-message; size larger than block_width_p.

Decomposition:
- Mask bit positions use bp_bedrock_mem_type_e from bp_common_pkg; no new package types.
- The num_stream and last_cnt arithmetic goes in a shared bp_me_pkg function, reused by the input pump.
- Reuse bsg_counter_set_en, bsg_mux_bitwise and bsg_dff_reset_set_clear.
- One natural sub-module: a bsg_two_fifo wrapper with active-low asynchronous reset, named bp_me_stream_out_buffer.

Test Plan:
- 1:1 write, stream 64b, block 512b, size 64B, addr 0x8010 -> 8 beats; addrs 0x8010, 0x8018, …, 0x8038, 0x8000, 0x8008; mem_last_o only on the 8th; fsm_new_o on beat 1 only.
- Uncached read, size 8B, addr 0x1004 -> 1 beat; addr 0x1004; mem_last_o = 1; fsm_done_o = 1 on accept; counter stays 0.
- 1:N, rd mask set on the mem side, size 32B, addr 0x2008 -> one FSM beat yields 4 beats at 0x2008, 0x2010, 0x2018, 0x2000; fsm_ready_and_o rises only with the 4th push.
- N:1, fsm side only, size 64B -> 7 FSM beats acked with no output; the 8th yields one beat with mem_last_o = 1.
- 64B message with mem_ready_and_i = 0 for cycles 2–5 -> buffer fills; fsm_ready_and_o = 0; mem_* stable; all 8 beats delivered in order.
- reset_n_i pulsed low after beat 3 of 8 -> outputs 0 immediately; next message starts at its own first_cnt; mem_last_o is correct.
